// File: rtl/xor_bind_checker_if.sv
// Checker sample/status bundle between the XOR stage tap and the checker.
// master: drives start/in_valid/a/b/c; slave: the checker, drives status.
interface xor_bind_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             in_valid;
  logic             a;
  logic             b;
  logic             c;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] first_err_idx;

  modport master (
    output start, in_valid, a, b, c,
    input  busy, done, pass, fail,
    input  sample_cnt, mismatch_cnt, first_err_idx
  );

  modport slave (
    input  start, in_valid, a, b, c,
    output busy, done, pass, fail,
    output sample_cnt, mismatch_cnt, first_err_idx
  );
endinterface

// File: rtl/xor_bind_checker.sv
// Run-based checker for the XOR stage: counts samples/mismatches, flags pass/fail.
// Ports: clk, rst_n (sync, active-low), chk (slave side of xor_bind_checker_if).
module xor_bind_checker #(
  parameter bit DOIT        = 1'b1,
  parameter int NUM_SAMPLES = 16,
  parameter int CNT_W       = 8
) (
  input logic          clk,
  input logic          rst_n,
  xor_bind_checker_if.slave chk
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] SAT  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             fail_q, fail_d;
  logic             busy_q, done_q, pass_q;
  logic             exp_c;
  logic             miss;

  assign exp_c = DOIT ? (chk.a ^ chk.b) : 1'b0;
  assign miss  = chk.c != exp_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (chk.start) begin
          state_d = RUN;
          cnt_d   = '0;
          mis_d   = '0;
          idx_d   = '0;
          fail_d  = 1'b0;
        end
      end
      RUN: begin
        if (chk.in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (miss) begin
            if (mis_q != SAT)
              mis_d = mis_q + 1'b1;
            if (!fail_q) begin
              fail_d = 1'b1;
              idx_d  = cnt_q;
            end
          end
          if (cnt_q == LAST)
            state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mis_q   <= '0;
      idx_q   <= '0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      busy_q  <= state_d == RUN;
      done_q  <= state_d == DONE;
      pass_q  <= (state_d == DONE) && (mis_d == '0);
    end
  end

  assign chk.busy          = busy_q;
  assign chk.done          = done_q;
  assign chk.pass          = pass_q;
  assign chk.fail          = fail_q;
  assign chk.sample_cnt    = cnt_q;
  assign chk.mismatch_cnt  = mis_q;
  assign chk.first_err_idx = idx_q;

endmodule

// File: doc/xor_bind_checker.md
Name: xor_bind_checker

Overview:
- Sequential checker that sits directly downstream of the parameter-inherited XOR stage bound into `foo`.
- Samples the stage's inputs `a`/`b` and its output `c` on every valid cycle.
- Recomputes the expected value as `DOIT ? a^b : 0`.
- Counts samples and mismatches over a fixed-length run and reports pass/fail.
- Bound alongside the XOR stage with `.doit` forwarded, so each `foo` instance checks against its own parameter value.

Parameters:
- DOIT, 1, same meaning as the upstream stage: 1 = XOR mode, 0 = output forced to 0.
- NUM_SAMPLES, 16, number of valid samples per run. Legal range 1 .. 2**CNT_W-1.
- CNT_W, 8, width of the sample counter, the mismatch counter and the error-index register.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  begins a run. Honoured only in IDLE or DONE.
- in_valid  input  1  a/b/c are a valid sample this cycle.
- a  input  1  upstream stage input a.
- b  input  1  upstream stage input b.
- c  input  1  upstream stage output c.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- pass  output  1  done & (mismatch_cnt == 0).
- fail  output  1  sticky; set on the first mismatch of a run.
- sample_cnt  output  CNT_W  valid samples accepted in the current or last run.
- mismatch_cnt  output  CNT_W  mismatches in the current or last run; saturating.
- first_err_idx  output  CNT_W  sample index (0-based) of the first mismatch. Meaningful only when fail=1.

Behaviour:
- Single clock domain; all outputs are registered.
- Reset, sampled on a clk edge with rst_n=0:
  - state=IDLE.
  - busy, done, pass, fail = 0.
  - sample_cnt, mismatch_cnt, first_err_idx = 0.
  - Reset mid-run aborts the run with no residue.
- Expected value: exp = DOIT ? (a ^ b) : 1'b0. Mismatch when in_valid & (c != exp).
- States IDLE, RUN, DONE.
- IDLE:
  - start=1 → clear all counters, clear fail → RUN next cycle.
  - in_valid is ignored, including when asserted in the same cycle as start.
- RUN:
  - Each cycle with in_valid=1:
    - sample_cnt increments by 1.
    - On mismatch, mismatch_cnt increments and saturates at 2**CNT_W-1, never wrapping.
    - On the first mismatch (fail was 0), first_err_idx ← the pre-increment sample_cnt and fail ← 1.
  - Counter and fail updates are visible in the cycle after the sample.
  - When the accepted sample makes sample_cnt reach NUM_SAMPLES → DONE next cycle. busy drops and done rises on the same edge.
  - start is ignored. in_valid=0 cycles leave all state unchanged; no timeout.
- DONE:
  - done=1 and pass is valid. Counters and fail hold; in_valid is ignored.
  - start=1 → same clearing as from IDLE → RUN next cycle; done drops on that edge.
- Invariants:
  - busy and done are never both high.
  - pass and fail are never both high.
  - sample_cnt never exceeds NUM_SAMPLES.

Test Plan:
- DOIT=1, NUM_SAMPLES=4: start, then 4 valid samples (a,b,c) = (0,0,0),(0,1,1),(1,0,1),(1,1,0) → sample_cnt=4, mismatch_cnt=0; done=1 and pass=1 one cycle after the 4th sample.
- DOIT=0, NUM_SAMPLES=4: same a/b with c=0 throughout → pass=1. Repeat with c=a^b → mismatch_cnt=2, fail=1 from the cycle after sample 1, first_err_idx=1, pass=0.
- DOIT=1: start, then valid samples separated by 3-cycle in_valid=0 gaps → counts advance only on valid cycles; still exactly 4 samples to DONE. start pulsed mid-RUN → no effect.
- CNT_W=3, NUM_SAMPLES=7, DOIT=1: c inverted on every sample → mismatch_cnt=7 (saturated, no wrap), first_err_idx=0, fail=1.
- Reset mid-run after 2 samples with 1 mismatch → the next cycle shows all outputs 0 and state IDLE. start + in_valid in the same cycle → that sample is not counted.
- In DONE: start → next cycle busy=1, done=0, counters=0, fail=0. A second full run yields fresh pass/fail independent of the previous run.
